softmax_row_seq: RTL and testbench

//  Row sequencer wrapped around one RU instance. Buffers one score vector, tracks its max and

---
 rtl/softmax_row_seq_if.sv | 31 +++
 rtl/softmax_row_seq.sv | 131 +++++++++++++
 tb/tb_softmax_row_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/softmax_row_seq_if.sv
// softmax_row_seq_if: score stream in, RU control/return lanes, probability stream out
interface softmax_row_seq_if #(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 32,
  parameter int ADDR_W = 6
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              ru_en;
  logic              ru_valid;
  logic [SUM_W-1:0]  ru_in0;
  logic [DATA_W-1:0] ru_in1;
  logic              sel_mult;
  logic              sel_mux;
  logic              ru_ret_valid;
  logic [DATA_W-1:0] ru_ret;
  logic              prob_valid;
  logic [DATA_W-1:0] prob;
  logic [ADDR_W-1:0] idx;
  logic              done;
  logic              busy;
  modport master (
    output valid, data, ru_ret_valid, ru_ret,
    input  ready, ru_en, ru_valid, ru_in0, ru_in1, sel_mult, sel_mux, prob_valid, prob, idx, done, busy
  );
  modport slave (
    input  valid, data, ru_ret_valid, ru_ret,
    output ready, ru_en, ru_valid, ru_in0, ru_in1, sel_mult, sel_mux, prob_valid, prob, idx, done, busy
  );
endinterface

// File: rtl/softmax_row_seq.sv
// softmax_row_seq: buffers one score row and replays it through RU (exp-sum pass, then normalize pass)
// SOFTMAX_SEQ_SAT_EN: sum saturates instead of wrapping and adds the sticky sat output
module softmax_row_seq #(
  parameter int VEC_LEN = 64,
  parameter int DATA_W  = 16,
  parameter int SUM_W   = 32,
  parameter int ADDR_W  = $clog2(VEC_LEN)
) (
  input  logic clk,
  input  logic rst_n,
  softmax_row_seq_if.slave bus
`ifdef SOFTMAX_SEQ_SAT_EN
  , output logic sat
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD, P1_ISSUE, P1_DRAIN, P2_ISSUE, P2_DRAIN, DONE} state_t;
  localparam logic [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [ADDR_W:0] ROW_LEN = (ADDR_W+1)'(VEC_LEN);
  state_t state;
  logic [DATA_W-1:0] mem [VEC_LEN];
  logic [ADDR_W-1:0] wr_cnt, rd;
  logic [ADDR_W:0] ret_cnt;
  logic signed [DATA_W-1:0] row_max;
  logic [SUM_W-1:0] sum;
  logic [DATA_W-1:0] rd_data;
  logic sel, accept, last_rd, p1, p2, issue, ret_in;
  assign accept = bus.valid && bus.ready;
  assign last_rd = rd == ADDR_W'(VEC_LEN-1);
  assign p1 = state == P1_ISSUE || state == P1_DRAIN;
  assign p2 = state == P2_ISSUE || state == P2_DRAIN;
  assign issue = state == P1_ISSUE || state == P2_ISSUE;
  assign ret_in = bus.ru_ret_valid && (p1 || p2);
  assign bus.ru_in1 = rd_data;
  assign bus.sel_mult = sel;
  assign bus.sel_mux = sel;
`ifdef SOFTMAX_SEQ_SAT_EN
  logic [SUM_W:0] sum_add;
  assign sum_add = {1'b0, sum} + {{(SUM_W+1-DATA_W){1'b0}}, bus.ru_ret};
`endif
  always_ff @(posedge clk)
    if (accept) mem[wr_cnt] <= bus.data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      wr_cnt <= '0;
      rd <= '0;
      ret_cnt <= '0;
      row_max <= MAX_INIT;
      sum <= '0;
      rd_data <= '0;
      sel <= 1'b0;
      bus.ready <= 1'b1;
      bus.ru_en <= 1'b0;
      bus.ru_valid <= 1'b0;
      bus.ru_in0 <= '0;
      bus.prob_valid <= 1'b0;
      bus.prob <= '0;
      bus.idx <= '0;
      bus.done <= 1'b0;
      bus.busy <= 1'b0;
`ifdef SOFTMAX_SEQ_SAT_EN
      sat <= 1'b0;
`endif
    end else begin
      bus.ru_en <= 1'b1;
      bus.ru_valid <= issue;
      rd_data <= issue ? mem[rd] : '0;
      bus.ru_in0 <= p1 ? {{(SUM_W-DATA_W){row_max[DATA_W-1]}}, row_max} : p2 ? sum : '0;
      bus.prob_valid <= ret_in && p2;
      if (ret_in && p2) begin
        bus.prob <= bus.ru_ret;
        bus.idx <= ret_cnt[ADDR_W-1:0];
      end
      if (ret_in) ret_cnt <= ret_cnt + 1'b1;
`ifdef SOFTMAX_SEQ_SAT_EN
      if (ret_in && p1) begin
        sum <= sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
        if (sum_add[SUM_W]) sat <= 1'b1;
      end
`else
      if (ret_in && p1) sum <= sum + SUM_W'(bus.ru_ret);
`endif
      if (issue) rd <= last_rd ? '0 : rd + 1'b1;
      unique case (state)
        IDLE: begin
`ifdef SOFTMAX_SEQ_SAT_EN
          sat <= 1'b0;
`endif
          if (accept) begin
            row_max <= bus.data;
            wr_cnt <= ADDR_W'(1);
            bus.busy <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: if (accept) begin
          row_max <= $signed(bus.data) > row_max ? bus.data : row_max;
          wr_cnt <= wr_cnt + 1'b1;
          if (wr_cnt == ADDR_W'(VEC_LEN-1)) begin
            bus.ready <= 1'b0;
            sel <= 1'b1;
            state <= P1_ISSUE;
          end
        end
        P1_ISSUE: if (last_rd) state <= P1_DRAIN;
        // mode flips only here, once every pass-1 op has returned
        P1_DRAIN: if (ret_cnt == ROW_LEN) begin
          ret_cnt <= '0;
          sel <= 1'b0;
          state <= P2_ISSUE;
        end
        P2_ISSUE: if (last_rd) state <= P2_DRAIN;
        P2_DRAIN: if (ret_cnt == ROW_LEN) begin
          bus.done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.ready <= 1'b1;
          bus.busy <= 1'b0;
          wr_cnt <= '0;
          rd <= '0;
          ret_cnt <= '0;
          sum <= '0;
          row_max <= MAX_INIT;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_softmax_row_seq.sv
// tb_softmax_row_seq: bench plays the RU with a fixed-latency queue and checks issue order, sums and probabilities
module tb_softmax_row_seq;
  localparam int N = 8, DW = 16, SW = 18, AW = $clog2(N), LAT = 13;
  localparam longint SMAX = (longint'(1) << SW) - 1;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  softmax_row_seq_if #(.DATA_W(DW), .SUM_W(SW), .ADDR_W(AW)) bus ();
`ifdef SOFTMAX_SEQ_SAT_EN
  logic sat;
`endif
  softmax_row_seq #(.VEC_LEN(N), .DATA_W(DW), .SUM_W(SW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
`ifdef SOFTMAX_SEQ_SAT_EN
    , .sat(sat)
`endif
  );
  int errs = 0, checks = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  typedef struct { int due; bit p1; int idx; } op_t;
  typedef struct { logic [DW-1:0] v; int idx; } prob_t;
  logic [DW-1:0] row[$];
  op_t pipe[$];
  prob_t want[$];
  longint msum = 0;
  bit msat = 0, exp_ready_hi = 0, p1, ret_fixed = 0;
  int iss = 0, cyc = 0, nacc = 0, ndone = 0, nprob = 0, m;
  logic [DW-1:0] ret_p1 = '0, ret_p2 = '0, v;
  logic [SW-1:0] p1_in0 = '0, p2_in0 = '0, e0;
  op_t op;
  prob_t pr;
  // RU model and scoreboard, evaluated away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      row.delete(); pipe.delete(); want.delete();
      iss = 0; msum = 0; msat = 0; exp_ready_hi = 0;
      bus.ru_ret_valid = 1'b0; bus.ru_ret = '0;
      chk("rst_ready", bus.ready, 1);
      chk("rst_outs", {bus.ru_en, bus.ru_valid, bus.ru_in0, bus.ru_in1, bus.sel_mult, bus.sel_mux,
                       bus.prob_valid, bus.prob, bus.idx, bus.done, bus.busy}, 0);
`ifdef SOFTMAX_SEQ_SAT_EN
      chk("rst_sat", sat, 0);
`endif
    end else begin
      if (exp_ready_hi) begin chk("ready_after_done", bus.ready, 1); exp_ready_hi = 0; end
      if (row.size() == N) chk("ready_low", bus.ready, 0);
      if (row.size() > 0) begin chk("busy", bus.busy, 1); chk("ru_en", bus.ru_en, 1); end
      if (bus.valid && bus.ready) begin row.push_back(bus.data); nacc++; end
      if (bus.ru_valid) begin
        if (row.size() != N || iss >= 2 * N) chk("issue_unexpected", iss, 2 * N);
        else begin
          p1 = iss < N;
          m = -32768;
          foreach (row[i]) if (int'($signed(row[i])) > m) m = int'($signed(row[i]));
          e0 = p1 ? SW'(m) : SW'(msum);
          chk("ru_in1", bus.ru_in1, row[iss % N]);
          chk("ru_in0", bus.ru_in0, e0);
          chk("sel_mult", bus.sel_mult, p1);
          chk("sel_mux", bus.sel_mux, p1);
          if (iss == 0) p1_in0 = bus.ru_in0;
          if (iss == N) p2_in0 = bus.ru_in0;
          pipe.push_back('{cyc + LAT, p1, iss % N});
          iss++;
        end
      end
      if (bus.prob_valid) begin
        if (want.size() == 0) chk("prob_spurious", 1, 0);
        else begin
          pr = want.pop_front();
          chk("prob", bus.prob, pr.v);
          chk("idx", bus.idx, pr.idx);
          nprob++;
        end
      end
      bus.ru_ret_valid = 1'b0;
      if (pipe.size() > 0 && pipe[0].due == cyc) begin
        op = pipe.pop_front();
        v = ret_fixed ? (op.p1 ? ret_p1 : ret_p2) : DW'($urandom);
        bus.ru_ret_valid = 1'b1;
        bus.ru_ret = v;
        if (op.p1) begin
`ifdef SOFTMAX_SEQ_SAT_EN
          msum = msum + longint'(v);
          if (msum > SMAX) begin msum = SMAX; msat = 1; end
`else
          msum = (msum + longint'(v)) % (SMAX + 1);
`endif
        end else want.push_back('{v, op.idx});
      end
      if (bus.done) begin
        chk("done_probs_left", want.size(), 0);
        chk("done_ops_left", pipe.size(), 0);
        chk("done_issues", iss, 2 * N);
`ifdef SOFTMAX_SEQ_SAT_EN
        chk("sat", sat, msat);
`endif
        row.delete(); iss = 0; msum = 0; msat = 0; ndone++; exp_ready_hi = 1;
      end
    end
  end
  logic [DW-1:0] stim [N];
  task automatic send_row();
    for (int i = 0; i < N; i++) begin
      int t = 0;
      @(posedge clk); #1;
      if ($urandom_range(3) == 0) begin bus.valid = 1'b0; @(posedge clk); #1; end
      bus.valid = 1'b1; bus.data = stim[i];
      @(negedge clk);
      while (!bus.ready && t < 300) begin t++; @(negedge clk); end
      if (!bus.ready) chk("accept_timeout", 0, 1);
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
  endtask
  task automatic wait_done(input int n0);
    int t = 0;
    while (ndone == n0 && t < 2000) begin @(negedge clk); t++; end
    chk("done_seen", ndone, n0 + 1);
  endtask
  task automatic run_row();
    int n0 = ndone;
    send_row();
    wait_done(n0);
  endtask
  task automatic rand_stim();
    foreach (stim[i]) stim[i] = DW'($urandom);
  endtask
  initial begin
    int n0, a0, np0, t;
    bus.valid = 1'b0; bus.data = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    ret_fixed = 1; ret_p1 = 16'h0400; ret_p2 = 16'h0100;
    foreach (stim[i]) stim[i] = '0;
    run_row();
    chk("t1_p1_in0", p1_in0, 0);
    chk("t1_sum", p2_in0, SW'(N * 16'h0400));
    ret_fixed = 0;
    foreach (stim[i]) stim[i] = '0;
    stim[0] = 16'h0400;
    run_row();
    chk("t2_max", p1_in0, SW'(32'h0000_0400));
    stim = '{16'hF000, 16'hF800, 16'hFC00, 16'hFE00, 16'hF400, 16'hF800, 16'hFC00, 16'hF000};
    run_row();
    chk("t3_max", p1_in0, SW'(32'hFFFF_FE00));
    rand_stim();
    n0 = ndone; np0 = nprob; t = 0;
    send_row();
    while (iss < N && t < 500) begin @(negedge clk); t++; end
    chk("t4_reach_drain", iss >= N, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (60) @(negedge clk);
    chk("t4_no_done", ndone, n0);
    chk("t4_no_prob", nprob, np0);
    rand_stim();
    run_row();
    n0 = ndone; a0 = nacc;
    for (int i = 0; i < 2 * N; i++) begin
      @(posedge clk); #1;
      bus.valid = 1'b1; bus.data = DW'($urandom);
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
    chk("t5_accepts", nacc - a0, N);
    wait_done(n0);
    rand_stim();
    run_row();
    ret_fixed = 1; ret_p1 = 16'hFFFF; ret_p2 = 16'h1234;
    rand_stim();
    run_row();
`ifdef SOFTMAX_SEQ_SAT_EN
    chk("t6_sum_sat", p2_in0, SMAX);
`else
    chk("t6_sum_wrap", p2_in0, SW'(N * 64'hFFFF));
`endif
    ret_fixed = 0;
    repeat (6) begin
      rand_stim();
      run_row();
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog errors=%0d checks=%0d", errs, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
